// File: rtl/sram_arbiter_if.sv
// Bundle of the instruction port, the data port and the single-port SRAM
// signals shared by the arbiter (slave) and its requesters/memory (master).
interface sram_arbiter_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [31:0]           i_rdata;

  logic                  d_req;
  logic [3:0]            d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [31:0]           d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [31:0]           d_rdata;

  logic                  sram_en;
  logic [3:0]            sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [31:0]           sram_wdata;
  logic [31:0]           sram_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, sram_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, sram_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between an instruction
// read port and a data read/write port; one access per cycle, 1-cycle response.
module sram_arbiter #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic           clk,
  input  logic           resetn,
  sram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INST,
    OWN_DATA
  } owner_t;

  typedef enum logic {
    LAST_INST,
    LAST_DATA
  } last_t;

  last_t                 last_p0;
  owner_t                owner_p1;
  logic                  gnt_i_p0;
  logic                  gnt_d_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [3:0]            we_p0;
  logic [31:0]           wdata_p0;

  // Stage 0: combinational grant in the request cycle. Gating with resetn
  // keeps every output at zero while reset is held.
  always_comb begin
    gnt_d_p0 = resetn && bus.d_req && (!bus.i_req || (last_p0 == LAST_INST));
    gnt_i_p0 = resetn && bus.i_req && !gnt_d_p0;
    addr_p0  = '0;
    we_p0    = '0;
    wdata_p0 = '0;
    if (gnt_d_p0) begin
      addr_p0  = bus.d_addr;
      we_p0    = bus.d_we;
      wdata_p0 = bus.d_wdata;
    end else if (gnt_i_p0) begin
      addr_p0  = bus.i_addr;
    end
  end

  assign bus.i_gnt      = gnt_i_p0;
  assign bus.d_gnt      = gnt_d_p0;
  assign bus.sram_en    = gnt_i_p0 | gnt_d_p0;
  assign bus.sram_addr  = addr_p0;
  assign bus.sram_we    = we_p0;
  assign bus.sram_wdata = wdata_p0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_p0  <= LAST_INST;
      owner_p1 <= OWN_NONE;
    end else begin
      if (gnt_d_p0) begin
        owner_p1 <= OWN_DATA;
        last_p0  <= LAST_DATA;
      end else if (gnt_i_p0) begin
        owner_p1 <= OWN_INST;
        last_p0  <= LAST_INST;
      end else begin
        owner_p1 <= OWN_NONE;
      end
    end
  end

  // Stage 1: response cycle; a data write still pulses d_rvalid as its ack.
  assign bus.i_rvalid = (owner_p1 == OWN_INST);
  assign bus.d_rvalid = (owner_p1 == OWN_DATA);
  assign bus.i_rdata  = (owner_p1 == OWN_INST) ? bus.sram_rdata : 32'h0;
  assign bus.d_rdata  = (owner_p1 == OWN_DATA) ? bus.sram_rdata : 32'h0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized
// requesters compared against a behavioural model of arbitration and memory.
module tb_sram_arbiter;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic mem_clear = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();
  sram_arbiter #(.ADDR_WIDTH(AW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Power-up memory contents, with the two words the directed cases rely on.
  function automatic logic [31:0] init_word(input logic [7:0] a);
    if (a == 8'h10) return 32'h12345678;
    if (a == 8'h20) return 32'h11111111;
    return {8'hC3, a, ~a, 8'h3C};
  endfunction

  // Single-port SRAM model: registered read, byte-strobed write.
  logic [31:0] sram_mem [0:255];
  logic        sram_wr  [0:255];

  function automatic logic [31:0] sram_word(input logic [7:0] a);
    return sram_wr[a] ? sram_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  we);
    logic [31:0] mask;
    mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int k = 0; k < 256; k++) sram_wr[k] <= 1'b0;
    end else if (bus.sram_en) begin
      bus.sram_rdata <= sram_word(bus.sram_addr[7:0]);
      if (bus.sram_we != 4'h0) begin
        sram_mem[bus.sram_addr[7:0]] <= byte_merge(sram_word(bus.sram_addr[7:0]),
                                                   bus.sram_wdata, bus.sram_we);
        sram_wr[bus.sram_addr[7:0]]  <= 1'b1;
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:255];
  bit          ref_last_d;
  bit          exp_iv, exp_dv, exp_d_wr;
  logic [31:0] exp_idata, exp_ddata;

  // Observed outputs of the most recent checked cycle
  logic        obs_gi, obs_gd, obs_en, obs_iv, obs_dv;
  logic [31:0] obs_irdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle();
    bit          e_gi, e_gd;
    logic [AW-1:0] e_addr;
    logic [3:0]  e_we;
    logic [31:0] e_wdata;
    logic [7:0]  a;
    obs_gi = bus.i_gnt;  obs_gd = bus.d_gnt;  obs_en = bus.sram_en;
    obs_iv = bus.i_rvalid; obs_dv = bus.d_rvalid; obs_irdata = bus.i_rdata;
    e_gi = 1'b0; e_gd = 1'b0;
    if (!resetn) begin
      ref_last_d = 1'b0; exp_iv = 1'b0; exp_dv = 1'b0; exp_d_wr = 1'b0;
    end else if (bus.i_req && bus.d_req) begin
      // Contention: whoever was not served last wins.
      if (ref_last_d) e_gi = 1'b1;
      else            e_gd = 1'b1;
    end else begin
      e_gi = bus.i_req;
      e_gd = bus.d_req;
    end
    e_addr = '0; e_we = 4'h0; e_wdata = 32'h0;
    if (e_gd) begin
      e_addr = bus.d_addr; e_we = bus.d_we; e_wdata = bus.d_wdata;
    end else if (e_gi) begin
      e_addr = bus.i_addr;
    end
    chk("i_gnt", bus.i_gnt, e_gi);
    chk("d_gnt", bus.d_gnt, e_gd);
    chk("gnt_excl", bus.i_gnt & bus.d_gnt, 0);
    chk("sram_en", bus.sram_en, e_gi | e_gd);
    chk("sram_we", bus.sram_we, e_we);
    chk("sram_addr", bus.sram_addr, e_addr);
    chk("sram_wdata", bus.sram_wdata, e_wdata);
    chk("i_rvalid", bus.i_rvalid, exp_iv);
    chk("d_rvalid", bus.d_rvalid, exp_dv);
    chk("i_rdata", bus.i_rdata, exp_iv ? exp_idata : 32'h0);
    if (!(exp_dv && exp_d_wr)) chk("d_rdata", bus.d_rdata, exp_dv ? exp_ddata : 32'h0);
    // Advance the model to the next cycle.
    exp_iv = e_gi; exp_dv = e_gd; exp_d_wr = e_gd && (e_we != 4'h0);
    if (e_gi) exp_idata = ref_mem[e_addr[7:0]];
    if (e_gd) begin
      a = e_addr[7:0];
      exp_ddata = ref_mem[a];
      for (int b = 0; b < 4; b++)
        if (e_we[b]) ref_mem[a][8*b +: 8] = e_wdata[8*b +: 8];
      ref_last_d = 1'b1;
    end else if (e_gi) begin
      ref_last_d = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 4'h0; bus.d_addr = '0; bus.d_wdata = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i[7:0]);
    ref_last_d = 1'b0; exp_iv = 1'b0; exp_dv = 1'b0; exp_d_wr = 1'b0;
    exp_idata = 32'h0; exp_ddata = 32'h0;
    idle_inputs();
    #1 resetn = 1'b0;
    step();
    // Requests during reset must not be granted.
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    step();
    chk("rst_no_gnt", {obs_gi, obs_gd}, 0);
    chk("rst_no_en", obs_en, 0);
    step();
    resetn = 1'b0; mem_clear = 1'b0;
    idle_inputs();
    step();
    resetn = 1'b1;

    // First contention after reset: d, i, d, i.
    bus.i_req = 1'b1; bus.i_addr = 16'h0005;
    bus.d_req = 1'b1; bus.d_addr = 16'h0006;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("ctn_order%0d", k), {obs_gi, obs_gd}, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    idle_inputs();
    step();

    // Lone instruction read.
    bus.i_req = 1'b1; bus.i_addr = 16'h0010;
    step();
    chk("iread_gnt", obs_gi, 1);
    chk("iread_en", obs_en, 1);
    idle_inputs();
    step();
    chk("iread_vld", obs_iv, 1);
    chk("iread_data", obs_irdata, 32'h12345678);

    // Partial data write followed by instruction read of the same word.
    bus.d_req = 1'b1; bus.d_we = 4'b0011; bus.d_addr = 16'h0020; bus.d_wdata = 32'hAABBCCDD;
    step();
    idle_inputs();
    bus.i_req = 1'b1; bus.i_addr = 16'h0020;
    step();
    chk("wr_ack", obs_dv, 1);
    chk("raw_gnt", obs_gi, 1);
    idle_inputs();
    step();
    chk("raw_data", obs_irdata, 32'h1111CCDD);

    // Back-to-back instruction reads, no bubbles.
    for (int k = 1; k <= 4; k++) begin
      if (k <= 3) begin
        bus.i_req = 1'b1; bus.i_addr = AW'(k);
      end else begin
        idle_inputs();
      end
      step();
      if (k >= 2) begin
        chk($sformatf("b2b_vld%0d", k - 1), obs_iv, 1);
        chk($sformatf("b2b_data%0d", k - 1), obs_irdata, init_word(8'(k - 1)));
      end
    end

    // Reset between a data-read grant and its response.
    bus.d_req = 1'b1; bus.d_addr = 16'h0007;
    step();
    chk("pre_rst_gnt", obs_gd, 1);
    resetn = 1'b0;
    idle_inputs();
    step();
    chk("rst_drop_vld", obs_dv, 0);
    step();
    resetn = 1'b1;
    bus.d_req = 1'b1; bus.d_addr = 16'h0008;
    step();
    chk("post_rst_vld", obs_dv, 0);
    chk("post_rst_gnt", obs_gd, 1);
    idle_inputs();
    step();

    // Quiet bus.
    step();
    chk("idle_en", obs_en, 0);
    chk("idle_vld", {obs_iv, obs_dv}, 0);
    chk("idle_rdata", obs_irdata, 0);

    // Randomized requesters that hold each request until it is granted.
    for (int c = 0; c < 3000; c++) begin
      if (!bus.i_req || obs_gi) begin
        bus.i_req  = ($urandom_range(0, 99) < 60);
        bus.i_addr = AW'($urandom_range(0, 63));
      end
      if (!bus.d_req || obs_gd) begin
        bus.d_req   = ($urandom_range(0, 99) < 60);
        bus.d_addr  = AW'($urandom_range(0, 63));
        bus.d_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        bus.d_wdata = $urandom;
      end
      step();
    end
    idle_inputs();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 16, giving the SRAM word-address width.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; every register samples on its rising edge.
REQ-003 The module SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port i_req, input, 1 bit: instruction-port read request.
REQ-005 The module SHALL have port i_addr, input, ADDR_WIDTH bits: instruction-port word address.
REQ-006 The module SHALL have port i_gnt, output, 1 bit: instruction request accepted this cycle.
REQ-007 The module SHALL have ports i_rvalid (output, 1 bit) and i_rdata (output, 32 bits): instruction read response.
REQ-008 The module SHALL have ports d_req (input, 1 bit), d_we (input, 4 bits, byte write strobes; 0 = read), d_addr (input, ADDR_WIDTH bits) and d_wdata (input, 32 bits): data-port request.
REQ-009 The module SHALL have ports d_gnt (output, 1 bit), d_rvalid (output, 1 bit) and d_rdata (output, 32 bits): data-port accept and response.
REQ-010 The module SHALL have ports sram_en (output, 1 bit), sram_we (output, 4 bits), sram_addr (output, ADDR_WIDTH bits) and sram_wdata (output, 32 bits): drive to the single-port SRAM.
REQ-011 The module SHALL have port sram_rdata, input, 32 bits: SRAM read data, valid the cycle after an enabled access and held until the next enabled access.

Function
REQ-012 Requester rules: once req is high, req and the address/strobe/write-data fields SHALL stay stable until gnt is seen high.
REQ-013 i_gnt and d_gnt SHALL be combinational in the request cycle and never both high in the same cycle.
REQ-014 A single requester SHALL be granted in the same cycle it requests, with no idle cycle needed between back-to-back grants.
REQ-015 Contention (i_req and d_req both high) SHALL be resolved round-robin: grant the port that was not granted most recently.
REQ-016 The last-granted pointer SHALL update on every grant; its reset value SHALL be "inst", so the data port wins the first contention.
REQ-017 sram_en SHALL equal i_gnt OR d_gnt.
REQ-018 On an i_gnt: sram_addr = i_addr, sram_we = 0.
REQ-019 On a d_gnt: sram_addr = d_addr, sram_we = d_we, sram_wdata = d_wdata.
REQ-020 With no grant: sram_we, sram_addr and sram_wdata SHALL be 0.
REQ-021 Response latency is exactly 1 cycle: a grant in cycle N SHALL produce a one-cycle rvalid pulse on that port in cycle N+1.
REQ-022 A granted data write SHALL also pulse d_rvalid in N+1 as a write acknowledge; d_rdata content in that cycle is don't-care.
REQ-023 A response-owner register (none/inst/data) SHALL be loaded every cycle from the grant outcome.
REQ-024 i_rdata and d_rdata SHALL equal sram_rdata while their rvalid is high, and 0 otherwise.
REQ-025 Responses have no backpressure; the requester SHALL capture the response in the rvalid cycle.
REQ-026 A new grant in cycle N+1 SHALL be permitted while the cycle-N response is being returned, giving full pipelining at 1 access per cycle.
REQ-027 A data write granted in cycle N followed by an instruction read of the same address granted in N+1 SHALL return the written data in N+2.

Reset
REQ-028 While resetn is low, all outputs SHALL be 0, the response owner SHALL be none, and the pointer SHALL be "inst", asynchronously.
REQ-029 Requests present while resetn is low SHALL NOT be granted.
REQ-030 If reset asserts between a grant and its response, the response SHALL be dropped, with no rvalid after reset release.
REQ-031 The first cycle after resetn rises SHALL arbitrate normally.

Verification
REQ-032 Bench SHALL cover: i_req alone, i_addr=0x0010, memory word = 0x12345678 -> i_gnt same cycle, sram_en=1, i_rvalid=1 with i_rdata=0x12345678 next cycle.
REQ-033 Bench SHALL cover: first contention after reset, both requests held 4 cycles -> grant order d, i, d, i; never both gnt high.
REQ-034 Bench SHALL cover: d write, d_we=4'b0011, d_wdata=0xAABBCCDD, to a word holding 0x11111111, then i read of the same word next cycle -> d_rvalid ack, then i_rdata=0x1111CCDD.
REQ-035 Bench SHALL cover: back-to-back i reads of addresses 1, 2, 3 -> i_rvalid high 3 consecutive cycles with matching data, no bubbles.
REQ-036 Bench SHALL cover: resetn pulsed low the cycle after a d read grant -> d_rvalid stays 0, all outputs 0 during reset, normal grant on the first cycle after release.
REQ-037 Bench SHALL cover: no requests -> sram_en=0, sram_we=0, both rvalid=0, both rdata=0.
